meas_fproc_arb: RTL and testbench

MEAS_FPROC_ARB -- requirements
Module: meas_fproc_arb

---
 rtl/meas_fproc_arb_if.sv | 26 ++
 rtl/meas_fproc_arb.sv | 221 ++++++++++++++++++++++
 tb/tb_meas_fproc_arb.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/meas_fproc_arb_if.sv
// Request/response bundle between the measurement units, the arbiter and the shared fproc port.
// master: the arbiter's view; slave: the units/fproc side.
interface meas_fproc_arb_if #(
    parameter int N_REQ          = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int FPROC_ID_WIDTH = 8
);
    logic [N_REQ-1:0]                     req_enable;
    logic [N_REQ-1:0][FPROC_ID_WIDTH-1:0] req_id;
    logic [N_REQ-1:0]                     req_ready;
    logic [DATA_WIDTH-1:0]                req_data;
    logic                                 fproc_enable;
    logic [FPROC_ID_WIDTH-1:0]            fproc_id;
    logic                                 fproc_ready;
    logic [DATA_WIDTH-1:0]                fproc_data;

    modport master (
        input  req_enable, req_id, fproc_ready, fproc_data,
        output req_ready, req_data, fproc_enable, fproc_id
    );

    modport slave (
        output req_enable, req_id, fproc_ready, fproc_data,
        input  req_ready, req_data, fproc_enable, fproc_id
    );
endinterface

// File: rtl/meas_fproc_arb.sv
// Round-robin arbiter sharing one fproc port among N_REQ measurement units.
// Optional WAIT timeout enabled by defining FPROC_ARB_TIMEOUT_EN.

// Per-unit request slot: pending bit, captured id, sticky overflow.
module meas_fproc_arb_slot #(
    parameter int ID_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_en,
    input  logic [ID_W-1:0] req_id,
    input  logic            clr,
    output logic            pending,
    output logic [ID_W-1:0] id_nxt,
    output logic            ovf
);
    logic            pending_d, pending_q;
    logic            ovf_d, ovf_q;
    logic [ID_W-1:0] id_d, id_q;

    // A slot being issued this cycle is already free for a new request.
    always_comb begin
        pending_d = pending_q & ~clr;
        id_d      = id_q;
        ovf_d     = ovf_q;
        if (req_en) begin
            if (pending_d) begin
                ovf_d = 1'b1;
            end else begin
                pending_d = 1'b1;
                id_d      = req_id;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= 1'b0;
            id_q      <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            id_q      <= id_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pending = pending_q;
    assign id_nxt  = id_d;
    assign ovf     = ovf_q;
endmodule

module meas_fproc_arb #(
    parameter int N_REQ          = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int FPROC_ID_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    meas_fproc_arb_if.master      bus,
    output logic                  busy,
    output logic [N_REQ-1:0]      overflow,
    output logic                  timeout_err
);
    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("meas_fproc_arb: N_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DELIVER
    } state_e;

    state_e                    state_d, state_q;
    logic [PTR_W-1:0]          grant_d, grant_q;
    logic [PTR_W-1:0]          rr_ptr_d, rr_ptr_q;
    logic [FPROC_ID_WIDTH-1:0] fproc_id_d, fproc_id_q;
    logic [DATA_WIDTH-1:0]     req_data_d, req_data_q;

    logic [N_REQ-1:0]                     pending;
    logic [N_REQ-1:0]                     clr;
    logic [N_REQ-1:0]                     cand;
    logic [N_REQ-1:0]                     req_ready_c;
    logic [N_REQ-1:0][FPROC_ID_WIDTH-1:0] slot_id_nxt;
    logic                                 win_found;
    logic [PTR_W-1:0]                     win_idx;

`ifdef FPROC_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_d, tmo_cnt_q;
    logic             timeout_err_d, timeout_err_q;
`endif

    for (genvar g = 0; g < N_REQ; g++) begin : g_slot
        meas_fproc_arb_slot #(.ID_W(FPROC_ID_WIDTH)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .req_en  (bus.req_enable[g]),
            .req_id  (bus.req_id[g]),
            .clr     (clr[g]),
            .pending (pending[g]),
            .id_nxt  (slot_id_nxt[g]),
            .ovf     (overflow[g])
        );
    end

    // Same-cycle requests count too, so an idle arbiter issues on the next cycle.
    assign cand = pending | bus.req_enable;

    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + 1 + k;
            if (idx >= N_REQ) idx -= N_REQ;
            if (!win_found && cand[PTR_W'(idx)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        clr         = '0;
        req_ready_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            clr[i]         = (state_q == S_ISSUE)   && (grant_q == PTR_W'(i));
            req_ready_c[i] = (state_q == S_DELIVER) && (grant_q == PTR_W'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        fproc_id_d = fproc_id_q;
        req_data_d = req_data_q;
`ifdef FPROC_ARB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d    = S_ISSUE;
                    grant_d    = win_idx;
                    rr_ptr_d   = win_idx;
                    fproc_id_d = slot_id_nxt[win_idx];
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef FPROC_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (bus.fproc_ready) begin
                    req_data_d = bus.fproc_data;
                    state_d    = S_DELIVER;
                end
`ifdef FPROC_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Give up: the unit still gets a strobe, with zero data.
                    req_data_d    = '0;
                    timeout_err_d = 1'b1;
                    state_d       = S_DELIVER;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            S_DELIVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= PTR_W'(N_REQ - 1);
            fproc_id_q <= '0;
            req_data_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            fproc_id_q <= fproc_id_d;
            req_data_q <= req_data_d;
        end
    end

`ifdef FPROC_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign bus.fproc_enable = (state_q == S_ISSUE);
    assign bus.fproc_id     = fproc_id_q;
    assign bus.req_ready    = req_ready_c;
    assign bus.req_data     = req_data_q;
    assign busy             = (state_q != S_IDLE);
endmodule

// File: tb/tb_meas_fproc_arb.sv
// Directed bench for meas_fproc_arb with a cycle-stamped transaction model checked every cycle.
// The timeout scenario runs only when FPROC_ARB_TIMEOUT_EN is defined.
module tb_meas_fproc_arb;
    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int IW  = 8;
    localparam int TMO = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    meas_fproc_arb_if #(.N_REQ(N), .DATA_WIDTH(DW), .FPROC_ID_WIDTH(IW)) bus ();
    logic         busy;
    logic [N-1:0] overflow;
    logic         timeout_err;

    meas_fproc_arb #(.N_REQ(N), .DATA_WIDTH(DW), .FPROC_ID_WIDTH(IW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- transaction model ----------------
    int            cyc = 0;
    bit            txn;
    int            issue_cyc, dlv_cyc, srv, rr;
    logic [IW-1:0] iss_id;
    logic [DW-1:0] res, last_data;
    bit            pend [N];
    logic [IW-1:0] mid  [N];
    logic [N-1:0]  movf;
    bit            mtmo;

    always @(negedge clk) begin
        bit           idle, exp_fen, exp_busy;
        logic [N-1:0] exp_rdy;
        cyc++;
        if (!reset) begin
            chk("rst_busy", busy, 0);
            chk("rst_fen", bus.fproc_enable, 0);
            chk("rst_rdy", bus.req_ready, 0);
            chk("rst_ovf", overflow, 0);
            chk("rst_data", bus.req_data, 0);
            chk("rst_tmo", timeout_err, 0);
            txn = 0; dlv_cyc = -1; issue_cyc = 0; srv = 0; rr = N - 1;
            movf = '0; mtmo = 0; last_data = '0; res = '0; iss_id = '0;
            for (int i = 0; i < N; i++) begin pend[i] = 0; mid[i] = '0; end
        end else begin
            exp_fen  = txn && (cyc == issue_cyc);
            exp_rdy  = (txn && cyc == dlv_cyc) ? (N'(1) << srv) : '0;
            exp_busy = txn && (cyc >= issue_cyc) && (dlv_cyc < 0 || cyc <= dlv_cyc);
            if (exp_rdy != 0) last_data = res;
            chk("m_fen", bus.fproc_enable, exp_fen);
            if (exp_fen) chk("m_fid", bus.fproc_id, iss_id);
            chk("m_rdy", bus.req_ready, exp_rdy);
            chk("m_data", bus.req_data, last_data);
            chk("m_busy", busy, exp_busy);
            chk("m_ovf", overflow, movf);
            chk("m_tmo", timeout_err, mtmo);

            idle = !txn || (dlv_cyc >= 0 && cyc > dlv_cyc);
            if (txn && cyc == issue_cyc) pend[srv] = 0;
            for (int i = 0; i < N; i++)
                if (bus.req_enable[i]) begin
                    if (pend[i]) movf[i] = 1'b1;
                    else begin pend[i] = 1; mid[i] = bus.req_id[i]; end
                end
            if (txn && cyc > issue_cyc && dlv_cyc < 0) begin
                if (bus.fproc_ready) begin
                    dlv_cyc = cyc + 1; res = bus.fproc_data;
                end
`ifdef FPROC_ARB_TIMEOUT_EN
                else if (cyc - issue_cyc == TMO) begin
                    dlv_cyc = cyc + 1; res = '0; mtmo = 1;
                end
`endif
            end
            if (idle) begin
                txn = 0;
                for (int k = 1; k <= N; k++) begin
                    int u;
                    u = (rr + k) % N;
                    if (!txn && pend[u]) begin
                        txn = 1; srv = u; rr = u; issue_cyc = cyc + 1; dlv_cyc = -1; iss_id = mid[u];
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fen(output logic [IW-1:0] id);
        int k;
        k = 0;
        while (bus.fproc_enable !== 1'b1 && k < 40) begin tick(); k++; end
        chk("fen_seen", bus.fproc_enable, 1);
        id = bus.fproc_id;
    endtask

    // Called in the ISSUE cycle: answer in the first WAIT cycle.
    task automatic respond(input logic [DW-1:0] d);
        tick();
        bus.fproc_ready = 1'b1;
        bus.fproc_data  = d;
        tick();
        bus.fproc_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] gid;
        int n;
        bus.req_enable  = '0;
        bus.req_id      = '0;
        bus.fproc_ready = 1'b0;
        bus.fproc_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_fid", bus.fproc_id, 0);
        chk("init_data", bus.req_data, 0);
        reset = 1'b1;
        tick();

        // single request, ready three cycles after the pulse
        bus.req_enable[2] = 1'b1; bus.req_id[2] = 8'h15;
        tick();
        bus.req_enable = '0;
        chk("t1_fen", bus.fproc_enable, 1);
        chk("t1_fid", bus.fproc_id, 8'h15);
        tick(); tick();
        bus.fproc_ready = 1'b1; bus.fproc_data = 32'hDEADBEEF;
        tick();
        bus.fproc_ready = 1'b0;
        chk("t1_rdy", bus.req_ready, 8'h04);
        chk("t1_data", bus.req_data, 32'hDEADBEEF);
        tick();

        // all units at once: served 0..7 (pointer last landed on 2, so reset first)
        reset = 1'b0; tick(); reset = 1'b1; tick();
        for (int u = 0; u < N; u++) begin
            bus.req_enable[u] = 1'b1; bus.req_id[u] = IW'(8'h40 + u);
        end
        tick();
        bus.req_enable = '0;
        for (int i = 0; i < N; i++) begin
            wait_fen(gid);
            chk($sformatf("t2_order%0d", i), gid, 8'h40 + i);
            respond(32'hA000_0000 + i);
        end
        chk("t2_ovf", overflow, 8'h00);
        tick();

        // unit 3 overflows while queued behind unit 0
        bus.req_enable[0] = 1'b1; bus.req_id[0] = 8'h30;
        bus.req_enable[3] = 1'b1; bus.req_id[3] = 8'h33;
        tick();
        bus.req_enable = '0;
        chk("t3_fid0", bus.fproc_id, 8'h30);
        tick();
        bus.req_enable[3] = 1'b1; bus.req_id[3] = 8'h99;
        tick();
        bus.req_enable = '0;
        tick();
        bus.req_enable[3] = 1'b1; bus.req_id[3] = 8'h9A;
        tick();
        bus.req_enable = '0;
        chk("t3_ovf", overflow, 8'h08);
        bus.fproc_ready = 1'b1; bus.fproc_data = 32'h3030_3030;
        tick();
        bus.fproc_ready = 1'b0;
        chk("t3_rdy0", bus.req_ready, 8'h01);
        wait_fen(gid);
        chk("t3_fid3", gid, 8'h33);
        respond(32'h3333_3333);
        chk("t3_rdy3", bus.req_ready, 8'h08);
        repeat (6) tick();

        // stray ready while idle, then reset in the middle of WAIT
        bus.fproc_ready = 1'b1; bus.fproc_data = 32'h0BAD_0BAD;
        tick(); tick();
        bus.fproc_ready = 1'b0;
        bus.req_enable[1] = 1'b1; bus.req_id[1] = 8'h11;
        tick();
        bus.req_enable = '0;
        tick();
        chk("t4_busy_wait", busy, 1);
        reset = 1'b0;
        tick();
        chk("t4_busy_rst", busy, 0);
        reset = 1'b1;
        tick();
        bus.fproc_ready = 1'b1; bus.fproc_data = 32'h1111_1111;
        tick();
        bus.fproc_ready = 1'b0;
        chk("t4_rdy", bus.req_ready, 8'h00);
        chk("t4_busy", busy, 0);
        chk("t4_ovf", overflow, 8'h00);
        repeat (5) tick();

        // unit 5 re-requests during its own WAIT
        bus.req_enable[5] = 1'b1; bus.req_id[5] = 8'h55;
        tick();
        bus.req_enable = '0;
        chk("t5_fid", bus.fproc_id, 8'h55);
        tick();
        bus.req_enable[5] = 1'b1; bus.req_id[5] = 8'h56;
        tick();
        bus.req_enable = '0;
        bus.fproc_ready = 1'b1; bus.fproc_data = 32'h5555_5555;
        tick();
        bus.fproc_ready = 1'b0;
        chk("t5_rdy1", bus.req_ready, 8'h20);
        wait_fen(gid);
        chk("t5_fid2", gid, 8'h56);
        respond(32'h5656_5656);
        chk("t5_rdy2", bus.req_ready, 8'h20);
        chk("t5_data2", bus.req_data, 32'h5656_5656);
        chk("t5_ovf", overflow, 8'h00);
        tick();

`ifdef FPROC_ARB_TIMEOUT_EN
        bus.req_enable[6] = 1'b1; bus.req_id[6] = 8'h66;
        tick();
        bus.req_enable = '0;
        n = 0;
        while (bus.req_ready === '0 && n < 40) begin tick(); n++; end
        chk("t6_wait", n, 11);
        chk("t6_rdy", bus.req_ready, 8'h40);
        chk("t6_data", bus.req_data, 0);
        chk("t6_tmo", timeout_err, 1);
`else
        n = 0;
        chk("t6_tmo_off", timeout_err, 0);
`endif
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
